// File: rtl/padding_ctrl_if.sv
// Handshake and frame-buffer bundle between the padding sequencer
// and its surroundings (control, frame buffer, conv line buffers).
interface padding_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (
        input  start, mem_rd_data, ready,
        output busy, done, mem_rd_en, mem_rd_addr, pxl_out, valid, last
    );

    modport slave (
        output start, mem_rd_data, ready,
        input  busy, done, mem_rd_en, mem_rd_addr, pxl_out, valid, last
    );
endinterface

// File: rtl/padding_ctrl.sv
// Zero-padding frame sequencer: walks a (D+2*PAD)^2 raster with explicit
// row/col counters, reads interior pixels from the frame buffer and
// streams a padded frame out with valid/ready backpressure.
module padding_ctrl #(
    parameter int unsigned D          = 220,
    parameter int unsigned PAD        = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    padding_if.master bus
);
    localparam int unsigned P  = D + 2 * PAD;
    localparam int unsigned CW = $clog2(P + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // S0: position counters and the running read address
    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [ADDR_WIDTH-1:0] r_addr;

    // S1: pad/last flags travelling alongside the outstanding read
    logic r_s1_valid;
    logic r_s1_pad;
    logic r_s1_last;

    // Output register
    logic [DATA_WIDTH-1:0] r_pxl;
    logic                  r_valid;
    logic                  r_last;

    logic          w_adv;
    logic          w_issue;
    logic          w_shift;
    logic          w_interior;
    logic          w_last_pos;
    logic [CW-1:0] w_row_off;
    logic [CW-1:0] w_col_off;

    // Offsets wrap to large values when row/col < PAD, so a single
    // unsigned compare against D covers both interior bounds.
    assign w_row_off  = r_row - CW'(PAD);
    assign w_col_off  = r_col - CW'(PAD);
    assign w_interior = (w_row_off < CW'(D)) && (w_col_off < CW'(D));
    assign w_last_pos = (r_row == CW'(P - 1)) && (r_col == CW'(P - 1));

    assign w_adv   = ~r_valid | bus.ready;
    assign w_issue = (r_state == RUN) && w_adv;
    assign w_shift = w_adv && ((r_state == RUN) || (r_state == DRAIN));

    assign bus.mem_rd_en   = w_issue && w_interior;
    assign bus.mem_rd_addr = r_addr;
    assign bus.pxl_out     = r_pxl;
    assign bus.valid       = r_valid;
    assign bus.last        = r_last;
    assign bus.busy        = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done        = (r_state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_issue && w_last_pos) w_state_next = DRAIN;
            DRAIN:   if (r_valid && r_last && bus.ready) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Position counters, pipeline stages and output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_pad   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_pxl      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_row  <= '0;
                r_col  <= '0;
                r_addr <= '0;
            end else if (w_issue) begin
                if (w_interior) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                if (r_col == CW'(P - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + CW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_shift) begin
                r_s1_valid <= w_issue;
                r_s1_pad   <= ~w_interior;
                r_s1_last  <= w_issue && w_last_pos;
                r_valid    <= r_s1_valid;
                r_pxl      <= (r_s1_valid && !r_s1_pad) ? bus.mem_rd_data : '0;
                r_last     <= r_s1_valid && r_s1_last;
            end
        end
    end
endmodule

// File: tb/tb_padding_ctrl.sv
// Scoreboard bench for padding_ctrl: three instances (4/1, 4/0, 220/3)
// share one clock and reset; frames are run one instance at a time.
module tb_padding_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a [3];
    logic        ready_a [3];
    logic        valid_a [3];
    logic        last_a  [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        rden_a  [3];
    logic [31:0] pxl_a   [3];
    logic [15:0] addr_a  [3];

    int          act   = 0;
    int          mode  = 0;
    int          ph    = 0;
    int          nvec  = 0;
    int          nerr  = 0;
    int          xfer  = 0;
    int          rdcnt = 0;
    logic [32:0] exp_q[$];
    logic        exp_done = 1'b0;
    logic        hold_v   = 1'b0;
    logic [32:0] hold_val = '0;

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int unsigned GD = (i == 2) ? 220 : 4;
        localparam int unsigned GP = (i == 0) ? 1 : ((i == 1) ? 0 : 3);

        padding_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

        padding_ctrl #(.D(GD), .PAD(GP), .DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus.master)
        );

        assign bus.start = start_a[i];
        assign bus.ready = ready_a[i];

        // frame buffer model: mem[a] = a + 100, one-cycle read, held between strobes
        always @(posedge clk) begin
            if (bus.mem_rd_en) bus.mem_rd_data <= 32'(bus.mem_rd_addr) + 32'd100;
        end

        assign valid_a[i] = bus.valid;
        assign last_a[i]  = bus.last;
        assign busy_a[i]  = bus.busy;
        assign done_a[i]  = bus.done;
        assign rden_a[i]  = bus.mem_rd_en;
        assign pxl_a[i]   = bus.pxl_out;
        assign addr_a[i]  = bus.mem_rd_addr;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_frame(input int d, input int pad);
        int p;
        p = d + 2 * pad;
        for (int r = 0; r < p; r++) begin
            for (int c = 0; c < p; c++) begin
                logic [31:0] v;
                logic        lst;
                if (r >= pad && r < pad + d && c >= pad && c < pad + d)
                    v = 32'((r - pad) * d + (c - pad) + 100);
                else
                    v = 32'd0;
                lst = (r == p - 1) && (c == p - 1);
                exp_q.push_back({lst, v});
            end
        end
    endtask

    // ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random (7/8 ready)
    initial begin
        for (int k = 0; k < 3; k++) ready_a[k] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            for (int k = 0; k < 3; k++) ready_a[k] = 1'b1;
            case (mode)
                1: ready_a[act] = ((ph % 4) == 0) || ((ph % 4) == 3);
                2: ready_a[act] = ($urandom_range(0, 7) != 0);
                default: ready_a[act] = 1'b1;
            endcase
        end
    end

    // monitor: pops the scoreboard on every transfer, checks stall stability and done timing
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v   = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done) begin
                check("done_pulse", 64'(done_a[act]), 64'd1);
                exp_done = 1'b0;
            end
            if (rden_a[act]) rdcnt++;
            if (valid_a[act]) begin
                if (hold_v) check("stall_hold", 64'({last_a[act], pxl_a[act]}), 64'(hold_val));
                if (ready_a[act]) begin
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL extra_beat: got %0h expected none at %0t", pxl_a[act], $time);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        check("pixel", 64'({last_a[act], pxl_a[act]}), 64'(e));
                    end
                    xfer++;
                    hold_v = 1'b0;
                    if (last_a[act]) exp_done = 1'b1;
                end else begin
                    hold_v   = 1'b1;
                    hold_val = {last_a[act], pxl_a[act]};
                end
            end else if (hold_v) begin
                check("valid_held", 64'(valid_a[act]), 64'd1);
                hold_v = 1'b0;
            end
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1 start_a[k] = 1'b1;
        @(posedge clk);
        #1 start_a[k] = 1'b0;
    endtask

    task automatic run_frame(input int k, input int md, input bit mid_start,
                             input int exp_x, input int exp_rd, input bit lat);
        int  n;
        bit  busy_ok;
        act   = k;
        mode  = md;
        xfer  = 0;
        rdcnt = 0;
        pulse_start(k);
        if (lat) begin
            @(negedge clk);
            check("busy_after_start", 64'(busy_a[k]), 64'd1);
            check("no_valid_t1", 64'(valid_a[k]), 64'd0);
            @(negedge clk);
            check("no_valid_t2", 64'(valid_a[k]), 64'd0);
            @(negedge clk);
            check("first_valid", 64'(valid_a[k]), 64'd1);
        end
        n       = 0;
        busy_ok = 1'b1;
        while (!done_a[k] && n < 70000) begin
            @(negedge clk);
            n++;
            if (!done_a[k] && !busy_a[k]) busy_ok = 1'b0;
            if (mid_start && n == 10) start_a[k] = 1'b1;
            if (mid_start && n == 11) start_a[k] = 1'b0;
        end
        if (!done_a[k]) begin
            nvec++;
            nerr++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
        end
        check("busy_until_done", 64'(busy_ok), 64'd1);
        check("transfers", 64'(xfer), 64'(exp_x));
        check("reads", 64'(rdcnt), 64'(exp_rd));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("idle_after_done", 64'({busy_a[k], done_a[k], valid_a[k]}), 64'd0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) start_a[k] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ctrl", 64'({valid_a[k], busy_a[k], done_a[k], last_a[k], rden_a[k]}), 64'd0);
            check("reset_addr", 64'(addr_a[k]), 64'd0);
            check("reset_pxl", 64'(pxl_a[k]), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: D=4 PAD=1, always ready
        push_frame(4, 1);
        run_frame(0, 0, 1'b0, 36, 16, 1'b1);

        // 2: ready toggling 1,0,0,1
        push_frame(4, 1);
        run_frame(0, 1, 1'b0, 36, 16, 1'b0);

        // 3: start pulsed mid-frame is ignored
        push_frame(4, 1);
        run_frame(0, 0, 1'b1, 36, 16, 1'b0);

        // 4: reset after 10 transfers, then a clean frame
        push_frame(4, 1);
        act  = 0;
        mode = 0;
        xfer = 0;
        pulse_start(0);
        n = 0;
        while (xfer < 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("abort_point", 64'(xfer), 64'd10);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", 64'(valid_a[0]), 64'd0);
        check("abort_busy", 64'(busy_a[0]), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_frame(4, 1);
        run_frame(0, 0, 1'b0, 36, 16, 1'b1);

        // 5: D=4 PAD=0
        push_frame(4, 0);
        run_frame(1, 0, 1'b0, 16, 16, 1'b1);

        // 6: D=220 PAD=3, random ready
        push_frame(220, 3);
        run_frame(2, 2, 1'b0, 51076, 48400, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
